prog_loader: RTL

Upstream loader that fills the processor's 16-entry, 9-bit writable program memory from a byte stream, then releases the processor core from reset. Sits between a byte source (UART receiver or test host) and the program memory write port plus core reset. The core is held in reset from power-up until a complete, valid program image has been written.

---
 rtl/prog_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: parses a count byte plus two-byte instructions, writes them in order
// and then releases the core from reset. PROG_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module prog_loader #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned INSTR_W = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               pm_we,
   output logic [ADDR_W-1:0]  pm_addr,
   output logic [INSTR_W-1:0] pm_data,
   output logic               cpu_rst,
   output logic               done,
   output logic               error
);

   typedef enum logic [2:0] {
      StIdle, StCount, StLo, StHi, StWrite, StChk, StRun, StError
   } state_t;

   localparam logic [7:0] MaxN = 8'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [INSTR_W-1:0]  data_q, data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      data_d  = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      // in_ready is high in every state that looks at in_valid, so in_valid implies a transfer
      case (state_q)
         StIdle, StRun, StError: begin
            if (start) begin
               state_d = StCount;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         StCount: begin
            if (in_valid) begin
               if (in_data == 8'h00 || in_data > MaxN) begin
                  state_d = StError;
               end else begin
                  last_d  = ADDR_W'(in_data - 8'd1);
                  idx_d   = '0;
                  state_d = StLo;
               end
            end
         end
         StLo: begin
            if (in_valid) begin
               data_d[7:0] = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d      = csum_q ^ in_data;
`endif
               state_d     = StHi;
            end
         end
         StHi: begin
            if (in_valid) begin
               if (|in_data[7:1]) begin
                  state_d = StError;
               end else begin
                  data_d[8] = in_data[0];
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_d    = csum_q ^ in_data;
`endif
                  state_d   = StWrite;
               end
            end
         end
         StWrite: begin
            if (idx_q == last_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               state_d = StChk;
`else
               state_d = StRun;
`endif
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StLo;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         StChk: begin
            if (in_valid) begin
               state_d = (in_data == csum_q) ? StRun : StError;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         last_q  <= '0;
         data_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         data_q  <= data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign in_ready = (state_q == StCount) || (state_q == StLo) || (state_q == StHi) ||
                     (state_q == StChk);
   assign pm_we    = (state_q == StWrite);
   assign pm_addr  = idx_q;
   assign pm_data  = data_q;
   assign cpu_rst  = (state_q != StRun);
   assign done     = (state_q == StRun);
   assign error    = (state_q == StError);

endmodule
